// File: rtl/pipelined_alu_if.sv
// Request/response bundle for pipelined_alu.
// master drives requests and out_ready_i; slave is the ALU side.
interface pipelined_alu_if #(
    parameter int DWIDTH = 8
) ();
    logic              in_valid_i;
    logic              in_ready_o;
    logic [2:0]        sel_i;
    logic [DWIDTH-1:0] op1_i;
    logic [DWIDTH-1:0] op2_i;
    logic              flush_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [DWIDTH-1:0] res_o;
    logic              zero_o;
    logic              neg_o;
    logic              carry_o;
    logic              ovf_o;
    logic              busy_o;

    modport master (
        output in_valid_i, sel_i, op1_i, op2_i, flush_i, out_ready_i,
        input  in_ready_o, out_valid_o, res_o,
        input  zero_o, neg_o, carry_o, ovf_o, busy_o
    );

    modport slave (
        input  in_valid_i, sel_i, op1_i, op2_i, flush_i, out_ready_i,
        output in_ready_o, out_valid_o, res_o,
        output zero_o, neg_o, carry_o, ovf_o, busy_o
    );
endinterface

// File: rtl/pipelined_alu.sv
// Pipelined ALU: combinational op then STAGES elastic register stages.
// Ports: clk, rst (async active-low), bus (pipelined_alu_if.slave).
module pipelined_alu #(
    parameter int DWIDTH = 8,
    parameter int STAGES = 3
) (
    input logic           clk,
    input logic           rst,
    pipelined_alu_if.slave bus
);
    localparam int SHW = $clog2(DWIDTH);
    localparam int MSB = DWIDTH - 1;

    typedef struct packed {
        logic [DWIDTH-1:0] res;
        logic              zero;
        logic              neg;
        logic              carry;
        logic              ovf;
    } ent_t;

    ent_t              alu_d;
    ent_t              data_q [STAGES];
    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] adv;
    logic              in_rdy;
    logic              accept;

    logic [DWIDTH:0]   sum;
    logic [DWIDTH:0]   dif;
    logic [SHW-1:0]    sh;
    logic [DWIDTH-1:0] a;
    logic [DWIDTH-1:0] b;

    assign a   = bus.op1_i;
    assign b   = bus.op2_i;
    assign sh  = b[SHW-1:0];
    assign sum = {1'b0, a} + {1'b0, b};
    assign dif = {1'b0, a} - {1'b0, b};

    always_comb begin
        alu_d = '0;
        unique case (bus.sel_i)
            3'd0: begin
                alu_d.res   = sum[DWIDTH-1:0];
                alu_d.carry = sum[DWIDTH];
                alu_d.ovf   = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
            end
            3'd1: begin
                // top bit of the widened difference is the borrow
                alu_d.res   = dif[DWIDTH-1:0];
                alu_d.carry = dif[DWIDTH];
                alu_d.ovf   = (a[MSB] != b[MSB]) && (dif[MSB] != a[MSB]);
            end
            3'd2: alu_d.res = a & b;
            3'd3: alu_d.res = a | b;
            3'd4: alu_d.res = a ^ b;
            3'd5: alu_d.res = a << sh;
            3'd6: alu_d.res = a >> sh;
            3'd7: alu_d.res = $signed(a) >>> sh;
            default: alu_d.res = '0;
        endcase
        alu_d.zero = (alu_d.res == '0);
        alu_d.neg  = alu_d.res[MSB];
    end

    // A stage may load when it is empty or its contents move on.
    always_comb begin
        logic nxt;
        adv = '0;
        nxt = !valid_q[STAGES-1] || bus.out_ready_i;
        adv[STAGES-1] = nxt;
        for (int k = STAGES - 2; k >= 0; k--) begin
            nxt    = !valid_q[k] || nxt;
            adv[k] = nxt;
        end
    end

    // rst term keeps in_ready low while reset is held.
    assign in_rdy = rst && !bus.flush_i && adv[0];
    assign accept = bus.in_valid_i && in_rdy;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                data_q[k] <= '0;
            end
        end else if (bus.flush_i) begin
            valid_q <= '0;
        end else begin
            if (adv[0]) begin
                valid_q[0] <= accept;
                if (accept) begin
                    data_q[0] <= alu_d;
                end
            end
            for (int k = 1; k < STAGES; k++) begin
                if (adv[k]) begin
                    valid_q[k] <= valid_q[k-1];
                    if (valid_q[k-1]) begin
                        data_q[k] <= data_q[k-1];
                    end
                end
            end
        end
    end

    assign bus.in_ready_o  = in_rdy;
    assign bus.out_valid_o = valid_q[STAGES-1];
    assign bus.res_o       = data_q[STAGES-1].res;
    assign bus.zero_o      = data_q[STAGES-1].zero;
    assign bus.neg_o       = data_q[STAGES-1].neg;
    assign bus.carry_o     = data_q[STAGES-1].carry;
    assign bus.ovf_o       = data_q[STAGES-1].ovf;
    assign bus.busy_o      = |valid_q;
endmodule

// File: tb/tb_pipelined_alu.sv
// Self-checking bench for pipelined_alu (DWIDTH=8, STAGES=3).
// Random and directed traffic against a queue-based reference model.
module tb_pipelined_alu;
    localparam int DW = 8;
    localparam int ST = 3;

    logic clk;
    logic rst;

    pipelined_alu_if #(.DWIDTH(DW)) bus ();

    pipelined_alu #(.DWIDTH(DW), .STAGES(ST)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    logic [11:0] exp_q [$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [11:0] obs();
        return {bus.res_o, bus.zero_o, bus.neg_o, bus.carry_o, bus.ovf_o};
    endfunction

    // Reference: plain integer arithmetic, {res, zero, neg, carry, ovf}.
    function automatic logic [11:0] ref_alu(input logic [2:0] s,
                                            input logic [7:0] a,
                                            input logic [7:0] b);
        int ua, ub, sa, sb, r, sr, sh;
        logic c, v;
        ua = a; ub = b;
        sa = (ua > 127) ? ua - 256 : ua;
        sb = (ub > 127) ? ub - 256 : ub;
        sh = ub % 8;
        c = 1'b0; v = 1'b0;
        case (s)
            3'd0: begin
                r = ua + ub; c = (r > 255);
                sr = sa + sb; v = (sr > 127) || (sr < -128);
            end
            3'd1: begin
                r = ua - ub; c = (ua < ub);
                sr = sa - sb; v = (sr > 127) || (sr < -128);
            end
            3'd2: r = ua & ub;
            3'd3: r = ua | ub;
            3'd4: r = ua ^ ub;
            3'd5: r = ua * (1 << sh);
            3'd6: r = ua / (1 << sh);
            default: begin
                sr = sa;
                repeat (sh) sr = (sr < 0) ? (sr - 1) / 2 : sr / 2;
                r = sr;
            end
        endcase
        r = ((r % 256) + 256) % 256;
        return {r[7:0], r == 0, r >= 128, c, v};
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        bus.in_valid_i  = 1'b0;
        bus.sel_i       = 3'd0;
        bus.op1_i       = '0;
        bus.op2_i       = '0;
        bus.flush_i     = 1'b0;
        bus.out_ready_i = 1'b1;
    endtask

    // Issue one op with out_ready high; lat = cycles after accept edge.
    task automatic send_wait(input logic [2:0] s, input logic [7:0] a,
                             input logic [7:0] b,
                             output logic [11:0] got, output int lat);
        bit seen;
        bus.sel_i = s; bus.op1_i = a; bus.op2_i = b;
        bus.in_valid_i = 1'b1; bus.out_ready_i = 1'b1;
        #1;
        lat = 0; got = '0; seen = 0;
        if (!bus.in_ready_o) lat = -1;
        tick();
        bus.in_valid_i = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            if (!seen && bus.out_valid_o) begin
                if (lat == 0) lat = c;
                got = obs();
                seen = 1;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (bus.out_valid_o !== 1'b0)
            $display("FAIL rst_out_valid: got %b want 0", bus.out_valid_o);
        else n_pass++;
        n_checks++;
        if (bus.busy_o !== 1'b0)
            $display("FAIL rst_busy: got %b want 0", bus.busy_o);
        else n_pass++;
        n_checks++;
        if (obs() !== 12'h000)
            $display("FAIL rst_data: got %h want 000", obs());
        else n_pass++;
        n_checks++;
        if (bus.in_ready_o !== 1'b0)
            $display("FAIL rst_in_ready: got %b want 0", bus.in_ready_o);
        else n_pass++;
        rst = 1'b1;
        tick();
        n_checks++;
        if (bus.in_ready_o !== 1'b1)
            $display("FAIL rel_in_ready: got %b want 1", bus.in_ready_o);
        else n_pass++;
    endtask

    task automatic test_latency();
        logic [11:0] got;
        int lat;
        send_wait(3'd0, 8'd10, 8'd3, got, lat);
        n_checks++;
        if (lat !== 3)
            $display("FAIL add_latency: got %0d want 3", lat);
        else n_pass++;
        n_checks++;
        if (got !== 12'h0D0)
            $display("FAIL add_10_3: got %h want 0d0", got);
        else n_pass++;
    endtask

    task automatic test_ops();
        logic [11:0] sels, got, want;
        logic [31:0] as, bs;
        logic [47:0] exps;
        int lat;
        sels = {3'd1, 3'd7, 3'd0, 3'd1};
        as   = {8'h05, 8'h80, 8'h7F, 8'h03};
        bs   = {8'h05, 8'h03, 8'h01, 8'h0A};
        exps = {12'h008, 12'hF04, 12'h805, 12'hF96};
        for (int i = 0; i < 4; i++) begin
            want = exps[12*i +: 12];
            send_wait(sels[3*i +: 3], as[8*i +: 8], bs[8*i +: 8], got, lat);
            n_checks++;
            if (got !== want || lat !== 3)
                $display("FAIL op%0d: got %h lat %0d want %h lat 3",
                         i, got, lat, want);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] sels;
        logic [31:0] as, bs, exps;
        logic [7:0]  res [4];
        int cyc [4];
        int nv;
        sels = {3'd4, 3'd3, 3'd2, 3'd0};
        as   = {8'hFF, 8'hA5, 8'hF0, 8'd10};
        bs   = {8'h0F, 8'h5A, 8'h0F, 8'd3};
        exps = {8'hF0, 8'hFF, 8'h00, 8'd13};
        nv = 0;
        bus.out_ready_i = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (bus.out_valid_o && nv < 4) begin
                res[nv] = bus.res_o;
                cyc[nv] = c;
                nv++;
            end
            bus.in_valid_i = (c < 4);
            if (c < 4) begin
                bus.sel_i = sels[3*c +: 3];
                bus.op1_i = as[8*c +: 8];
                bus.op2_i = bs[8*c +: 8];
            end
            tick();
        end
        n_checks++;
        if (nv !== 4)
            $display("FAIL b2b_count: got %0d want 4", nv);
        else n_pass++;
        for (int i = 0; i < nv; i++) begin
            n_checks++;
            if (res[i] !== exps[8*i +: 8] || cyc[i] !== 3 + i)
                $display("FAIL b2b_%0d: got %h@%0d want %h@%0d",
                         i, res[i], cyc[i], exps[8*i +: 8], 3 + i);
            else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        logic [11:0] held, e;
        bit have;
        int k, dlv;
        exp_q.delete();
        k = 0; dlv = 0; have = 0; held = '0;
        bus.out_ready_i = 1'b0;
        bus.sel_i = 3'd0;
        for (int c = 0; c < 8; c++) begin
            bus.in_valid_i = (k < 5);
            bus.op1_i = 8'(20 * k + 1);
            bus.op2_i = 8'(k);
            #1;
            if (bus.out_valid_o) begin
                if (have) begin
                    n_checks++;
                    if (obs() !== held)
                        $display("FAIL bp_stable: got %h want %h",
                                 obs(), held);
                    else n_pass++;
                end
                held = obs(); have = 1;
            end
            if (bus.in_valid_i && bus.in_ready_o) begin
                exp_q.push_back(ref_alu(3'd0, bus.op1_i, bus.op2_i));
                k++;
            end
            tick();
        end
        n_checks++;
        if (k !== 3)
            $display("FAIL bp_accepted: got %0d want 3", k);
        else n_pass++;
        n_checks++;
        if (bus.in_ready_o !== 1'b0)
            $display("FAIL bp_in_ready: got %b want 0", bus.in_ready_o);
        else n_pass++;
        bus.out_ready_i = 1'b1;
        for (int c = 0; c < 20; c++) begin
            bus.in_valid_i = (k < 5);
            bus.op1_i = 8'(20 * k + 1);
            bus.op2_i = 8'(k);
            #1;
            if (bus.out_valid_o) begin
                dlv++;
                n_checks++;
                if (exp_q.size() == 0)
                    $display("FAIL bp_order: got %h want none", obs());
                else begin
                    e = exp_q.pop_front();
                    if (obs() !== e)
                        $display("FAIL bp_order: got %h want %h", obs(), e);
                    else n_pass++;
                end
            end
            if (bus.in_valid_i && bus.in_ready_o) begin
                exp_q.push_back(ref_alu(3'd0, bus.op1_i, bus.op2_i));
                k++;
            end
            tick();
        end
        n_checks++;
        if (dlv !== 5 || k !== 5 || exp_q.size() != 0)
            $display("FAIL bp_total: got %0d/%0d left %0d want 5/5 left 0",
                     dlv, k, exp_q.size());
        else n_pass++;
    endtask

    task automatic test_flush();
        logic [11:0] got;
        int lat;
        bus.out_ready_i = 1'b1;
        bus.sel_i = 3'd0; bus.op1_i = 8'd9; bus.op2_i = 8'd9;
        bus.in_valid_i = 1'b1;
        tick();
        tick();
        bus.flush_i = 1'b1;
        #1;
        n_checks++;
        if (bus.in_ready_o !== 1'b0)
            $display("FAIL flush_in_ready: got %b want 0", bus.in_ready_o);
        else n_pass++;
        tick();
        bus.flush_i = 1'b0;
        bus.in_valid_i = 1'b0;
        #1;
        n_checks++;
        if (bus.out_valid_o !== 1'b0 || bus.busy_o !== 1'b0)
            $display("FAIL flush_clear: got v%b b%b want v0 b0",
                     bus.out_valid_o, bus.busy_o);
        else n_pass++;
        @(negedge clk);
        send_wait(3'd0, 8'd1, 8'd1, got, lat);
        n_checks++;
        if (got !== 12'h020 || lat !== 3)
            $display("FAIL flush_after: got %h lat %0d want 020 lat 3",
                     got, lat);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [11:0] e, prev;
        bit held;
        exp_q.delete();
        held = 0; prev = '0;
        for (int i = 0; i < 400; i++) begin
            bus.in_valid_i  = ($urandom_range(0, 3) != 0);
            bus.sel_i       = 3'($urandom_range(0, 7));
            bus.op1_i       = 8'($urandom);
            bus.op2_i       = 8'($urandom);
            bus.out_ready_i = ($urandom_range(0, 2) != 0);
            bus.flush_i     = ($urandom_range(0, 59) == 0);
            #1;
            n_checks++;
            if (bus.in_ready_o !== (!bus.flush_i &&
                (exp_q.size() < ST || bus.out_ready_i)))
                $display("FAIL rnd_in_ready: got %b want %b", bus.in_ready_o,
                         !bus.flush_i && (exp_q.size() < ST ||
                         bus.out_ready_i));
            else n_pass++;
            if (held && bus.out_valid_o) begin
                n_checks++;
                if (obs() !== prev)
                    $display("FAIL rnd_stable: got %h want %h", obs(), prev);
                else n_pass++;
            end
            if (bus.out_valid_o && bus.out_ready_i) begin
                n_checks++;
                if (exp_q.size() == 0)
                    $display("FAIL rnd_data: got %h want none", obs());
                else begin
                    e = exp_q.pop_front();
                    if (obs() !== e)
                        $display("FAIL rnd_data: got %h want %h", obs(), e);
                    else n_pass++;
                end
            end
            held = bus.out_valid_o && !bus.out_ready_i && !bus.flush_i;
            prev = obs();
            if (bus.flush_i) exp_q.delete();
            else if (bus.in_valid_i && bus.in_ready_o)
                exp_q.push_back(ref_alu(bus.sel_i, bus.op1_i, bus.op2_i));
            tick();
        end
        idle();
        for (int c = 0; c < 10; c++) begin
            #1;
            if (bus.out_valid_o) begin
                n_checks++;
                if (exp_q.size() == 0)
                    $display("FAIL rnd_drain: got %h want none", obs());
                else begin
                    e = exp_q.pop_front();
                    if (obs() !== e)
                        $display("FAIL rnd_drain: got %h want %h", obs(), e);
                    else n_pass++;
                end
            end
            tick();
        end
        n_checks++;
        if (exp_q.size() != 0 || bus.busy_o !== 1'b0)
            $display("FAIL rnd_empty: got left %0d busy %b want 0 0",
                     exp_q.size(), bus.busy_o);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int cnt;
        idle();
        bus.out_ready_i = 1'b0;
        bus.sel_i = 3'd0; bus.op1_i = 8'd10; bus.op2_i = 8'd3;
        bus.in_valid_i = 1'b1;
        repeat (3) tick();
        bus.in_valid_i = 1'b0;
        n_checks++;
        if (bus.out_valid_o !== 1'b1 || bus.res_o !== 8'd13)
            $display("FAIL rm_pre: got v%b %h want v1 0d",
                     bus.out_valid_o, bus.res_o);
        else n_pass++;
        #2;
        rst = 1'b0;
        #1;
        n_checks++;
        if (bus.out_valid_o !== 1'b0 || bus.busy_o !== 1'b0)
            $display("FAIL rm_valid: got v%b b%b want v0 b0",
                     bus.out_valid_o, bus.busy_o);
        else n_pass++;
        n_checks++;
        if (obs() !== 12'h000 || bus.in_ready_o !== 1'b0)
            $display("FAIL rm_data: got %h r%b want 000 r0",
                     obs(), bus.in_ready_o);
        else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        bus.out_ready_i = 1'b1;
        cnt = 0;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (bus.out_valid_o) cnt++;
            tick();
        end
        n_checks++;
        if (cnt !== 0)
            $display("FAIL rm_stale: got %0d beats want 0", cnt);
        else n_pass++;
    endtask

    initial begin
        rst = 1'b0;
        idle();
        test_reset();
        test_latency();
        test_ops();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
